// File: rtl/btn_debouncer_mc.sv
// Multi-channel button debouncer: per-channel synchroniser, symmetric debounce filter and press-duration FSM.
// Define BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN to enable double-click detection (adds GAP/PRS2 states).
module btn_debouncer_mc #(
  parameter int unsigned NUM_BTNS            = 4,
  parameter int unsigned CLK_FREQUENCY       = 100000000,
  parameter bit          BUTTON_INPUT_LEVEL  = 1'b1,
  parameter int unsigned DEBOUNCE_MS         = 10,
  parameter int unsigned LONG_PRESS_MS       = 1000,
  parameter int unsigned DOUBLE_CLICK_GAP_MS = 250
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] usr_btn,
  output logic [NUM_BTNS-1:0] press,
  output logic [NUM_BTNS-1:0] long_press,
  output logic [NUM_BTNS-1:0] click,
  output logic [NUM_BTNS-1:0] long_pulse,
  output logic [NUM_BTNS-1:0] double_click
);

  localparam int unsigned CLKS_PER_MS     = CLK_FREQUENCY / 1000;
  localparam int unsigned DEB_RAW         = CLKS_PER_MS * DEBOUNCE_MS;
  localparam int unsigned DEBOUNCE_CLKS   = (DEB_RAW == 0) ? 1 : DEB_RAW;
  localparam int unsigned LONG_RAW        = (LONG_PRESS_MS == 0) ? 10 * DEBOUNCE_CLKS
                                                                 : CLKS_PER_MS * LONG_PRESS_MS;
  localparam int unsigned LONG_PRESS_CLKS = (LONG_RAW == 0) ? 1 : LONG_RAW;
  localparam int unsigned GAP_RAW         = CLKS_PER_MS * DOUBLE_CLICK_GAP_MS;
  localparam int unsigned GAP_CLKS        = (GAP_RAW == 0) ? 1 : GAP_RAW;
  localparam int unsigned DEB_W           = $clog2(DEBOUNCE_CLKS + 1);
  localparam int unsigned DUR_W           = $clog2(LONG_PRESS_CLKS + 1);
  localparam int unsigned GAP_W           = $clog2(GAP_CLKS + 1);

  if (NUM_BTNS == 0 || NUM_BTNS > 32 || GAP_W == 0) begin : g_param_check
    $error("btn_debouncer_mc: NUM_BTNS must be in 1..32");
  end

`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
  typedef enum logic [2:0] {REL = 3'd0, PRS = 3'd1, LNG = 3'd2, GAP = 3'd3, PRS2 = 3'd4} state_e;
`else
  typedef enum logic [1:0] {REL = 2'd0, PRS = 2'd1, LNG = 2'd2} state_e;
`endif

  for (genvar i = 0; i < int'(NUM_BTNS); i++) begin : g_ch
    logic [1:0]       sync_q;
    logic             s_c;
    logic             toggle_c;
    logic             rise_c;
    logic             fall_c;
    logic             press_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DUR_W-1:0] dur_cnt_q;
    state_e           state_q;
    state_e           state_d;
    logic             long_press_q;
    logic             long_press_d;
    logic             click_q;
    logic             click_d;
    logic             long_pulse_q;
    logic             long_pulse_d;
    logic             at_long_c;

    // Two-flop synchroniser, parked at the released level
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= {2{~BUTTON_INPUT_LEVEL}};
      else       sync_q <= {sync_q[0], usr_btn[i]};
    end

    assign s_c       = (sync_q[1] == BUTTON_INPUT_LEVEL);
    assign toggle_c  = (s_c != press_q) && (deb_cnt_q == DEB_W'(DEBOUNCE_CLKS - 1));
    assign rise_c    = toggle_c && !press_q;
    assign fall_c    = toggle_c && press_q;
    assign at_long_c = (dur_cnt_q == DUR_W'(LONG_PRESS_CLKS - 1));

    // Symmetric filter: the input must disagree with press for DEBOUNCE_CLKS cycles
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        press_q   <= 1'b0;
        deb_cnt_q <= '0;
      end else begin
        press_q <= press_q ^ toggle_c;
        if (s_c == press_q || toggle_c) deb_cnt_q <= '0;
        else                            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end

    // Press duration, saturating at the long-press threshold
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                                dur_cnt_q <= '0;
      else if (rise_c)                                          dur_cnt_q <= '0;
      else if (press_q && dur_cnt_q != DUR_W'(LONG_PRESS_CLKS)) dur_cnt_q <= dur_cnt_q + DUR_W'(1);
    end

`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
    logic [GAP_W-1:0] gap_cnt_q;
    logic             dclick_q;
    logic             dclick_d;

    // Released time since a first short click; zero whenever not waiting
    always_ff @(posedge clk or posedge reset) begin
      if (reset)               gap_cnt_q <= '0;
      else if (state_q != GAP) gap_cnt_q <= '0;
      else                     gap_cnt_q <= gap_cnt_q + GAP_W'(1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q      <= REL;
        long_press_q <= 1'b0;
        click_q      <= 1'b0;
        long_pulse_q <= 1'b0;
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
        dclick_q     <= 1'b0;
`endif
      end else begin
        state_q      <= state_d;
        long_press_q <= long_press_d;
        click_q      <= click_d;
        long_pulse_q <= long_pulse_d;
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
        dclick_q     <= dclick_d;
`endif
      end
    end

    // Release wins over reaching the long threshold in the same cycle
    always_comb begin
      state_d      = state_q;
      click_d      = 1'b0;
      long_pulse_d = 1'b0;
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
      dclick_d     = 1'b0;
`endif
      case (state_q)
        REL: if (rise_c) state_d = PRS;
        PRS: begin
          if (fall_c) begin
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
            state_d = GAP;
`else
            state_d = REL;
            click_d = 1'b1;
`endif
          end else if (at_long_c) begin
            state_d      = LNG;
            long_pulse_d = 1'b1;
          end
        end
        LNG: if (fall_c) state_d = REL;
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
        GAP: begin
          if (rise_c) begin
            state_d = PRS2;
          end else if (gap_cnt_q == GAP_W'(GAP_CLKS - 1)) begin
            state_d = REL;
            click_d = 1'b1;
          end
        end
        PRS2: begin
          if (fall_c) begin
            state_d  = REL;
            dclick_d = 1'b1;
          end else if (at_long_c) begin
            state_d      = LNG;
            long_pulse_d = 1'b1;
          end
        end
`endif
        default: state_d = REL;
      endcase
      long_press_d = (state_d == LNG);
    end

    assign press[i]      = press_q;
    assign long_press[i] = long_press_q;
    assign click[i]      = click_q;
    assign long_pulse[i] = long_pulse_q;
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
    assign double_click[i] = dclick_q;
`else
    assign double_click[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_btn_debouncer_mc.sv
// Directed self-checking bench for btn_debouncer_mc (1 MHz clock: 1000-clk debounce, 10000-clk long press,
// 5000-clk double-click gap). Follows BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN if defined.
module tb_btn_debouncer_mc;

  localparam int N = 4;
  localparam int D = 1000;
  localparam int L = 10000;
  localparam int G = 5000;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] usr_btn;
  logic [N-1:0] press;
  logic [N-1:0] long_press;
  logic [N-1:0] click;
  logic [N-1:0] long_pulse;
  logic [N-1:0] double_click;

  int total = 0;
  int bad   = 0;
  int click_n [N] = '{default: 0};
  int lp_n    [N] = '{default: 0};
  int dc_n    [N] = '{default: 0};
  int pr_n    [N] = '{default: 0};
  int snap_c  [N] = '{default: 0};
  int snap_lp [N] = '{default: 0};
  int snap_dc [N] = '{default: 0};
  int snap_pr [N] = '{default: 0};

  btn_debouncer_mc #(
    .NUM_BTNS(N), .CLK_FREQUENCY(1000000), .BUTTON_INPUT_LEVEL(1'b1),
    .DEBOUNCE_MS(1), .LONG_PRESS_MS(10), .DOUBLE_CLICK_GAP_MS(5)
  ) dut (
    .clk(clk), .reset(reset), .usr_btn(usr_btn), .press(press), .long_press(long_press),
    .click(click), .long_pulse(long_pulse), .double_click(double_click)
  );

  always #5 clk = ~clk;

  // Count high cycles of every output per channel
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (click[i])        click_n[i]++;
      if (long_pulse[i])   lp_n[i]++;
      if (double_click[i]) dc_n[i]++;
      if (press[i])        pr_n[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < N; i++) begin
      snap_c[i]  = click_n[i];
      snap_lp[i] = lp_n[i];
      snap_dc[i] = dc_n[i];
      snap_pr[i] = pr_n[i];
    end
  endtask

  function automatic int d_click(input int ch); return click_n[ch] - snap_c[ch]; endfunction
  function automatic int d_lp(input int ch);    return lp_n[ch] - snap_lp[ch];   endfunction
  function automatic int d_dc(input int ch);    return dc_n[ch] - snap_dc[ch];   endfunction
  function automatic int d_pr(input int ch);    return pr_n[ch] - snap_pr[ch];   endfunction

  function automatic int d_pulses_all();
    int s = 0;
    for (int i = 0; i < N; i++) s += d_click(i) + d_lp(i) + d_dc(i);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    usr_btn = '0;
    tick(3);
    check("reset_outputs", {press, long_press, click, long_pulse, double_click}, 32'h0);
    reset = 1'b0;
    tick(5);
    check("idle_outputs", {press, long_press, click, long_pulse, double_click}, 32'h0);

    // Glitch of D-1 cycles on ch0
    snap();
    usr_btn[0] = 1'b1;
    tick(D - 1);
    usr_btn[0] = 1'b0;
    tick(D + 10);
    check("glitch_press", d_pr(0), 0);
    check("glitch_pulses", d_pulses_all(), 0);

    // Short press on ch1, 3000 cycles
    snap();
    usr_btn[1] = 1'b1;
    tick(D + 1);
    check("short_pre_rise", press[1], 0);
    tick(1);
    check("short_rise", press[1], 1);
    tick(3000 - (D + 2));
    usr_btn[1] = 1'b0;
    tick(D + 1);
    check("short_pre_fall", press[1], 1);
    tick(1);
    check("short_fall", press[1], 0);
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
    check("short_click_held", click[1], 0);
    tick(G - 1);
    check("short_click_pre", click[1], 0);
    tick(1);
    check("short_click", click[1], 1);
`else
    check("short_click", click[1], 1);
`endif
    tick(1);
    check("short_click_width", click[1], 0);
    tick(20);
    check("short_click_count", d_click(1), 1);
    check("short_no_long", d_lp(1), 0);

    // Long press on ch2, 12000 cycles
    snap();
    usr_btn[2] = 1'b1;
    tick(D + 2);
    check("long_rise", press[2], 1);
    tick(L - 1);
    check("long_level_pre", long_press[2], 0);
    check("long_pulse_pre", long_pulse[2], 0);
    tick(1);
    check("long_level", long_press[2], 1);
    check("long_pulse", long_pulse[2], 1);
    tick(1);
    check("long_pulse_width", long_pulse[2], 0);
    tick(12000 - (D + 2) - L - 1);
    usr_btn[2] = 1'b0;
    tick(D + 1);
    check("long_level_held", long_press[2], 1);
    tick(1);
    check("long_fall_press", press[2], 0);
    check("long_fall_level", long_press[2], 0);
    tick(G + 20);
    check("long_no_click", d_click(2), 0);
    check("long_pulse_count", d_lp(2), 1);

    // Two short presses on ch3 with a 2000-cycle gap
    snap();
    usr_btn[3] = 1'b1;
    tick(2000);
    usr_btn[3] = 1'b0;
    tick(2000);
    usr_btn[3] = 1'b1;
    tick(2000);
    usr_btn[3] = 1'b0;
    tick(D + 1);
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
    check("dbl_pre", double_click[3], 0);
    tick(1);
    check("dbl_pulse", double_click[3], 1);
    tick(1);
    check("dbl_width", double_click[3], 0);
    tick(G + 20);
    check("dbl_no_click", d_click(3), 0);
    check("dbl_count", d_dc(3), 1);
`else
    check("dbl_pre", click[3], 0);
    tick(1);
    check("dbl_second_click", click[3], 1);
    tick(G + 20);
    check("dbl_click_count", d_click(3), 2);
    check("dbl_tied_zero", d_dc(3), 0);
`endif

    // All channels pressed together; ch0/1 released first
    snap();
    usr_btn = 4'hF;
    tick(D + 1);
    check("conc_pre_rise", press, 4'h0);
    tick(1);
    check("conc_rise", press, 4'hF);
    tick(3000 - (D + 2));
    usr_btn = 4'b1100;
    tick(D + 1);
    check("conc_pre_fall", press, 4'hF);
    tick(1);
    check("conc_fall", press, 4'b1100);
`ifdef BTN_DEBOUNCER_MC_DOUBLE_CLICK_EN
    check("conc_click_held", click, 4'h0);
    tick(G - 1);
    check("conc_click_pre", click, 4'h0);
    tick(1);
`endif
    check("conc_click", click, 4'b0011);
    check("conc_others_held", press, 4'b1100);
    usr_btn = 4'h0;
    tick(D + 2 + G + 20);
    for (int i = 0; i < N; i++) begin
      check($sformatf("conc_click_cnt%0d", i), d_click(i), 1);
      check($sformatf("conc_no_long%0d", i), d_lp(i), 0);
    end

    // Reset while ch0 is held; the held button must be re-debounced
    snap();
    usr_btn[0] = 1'b1;
    tick(5000);
    check("rst_pressed", press[0], 1);
    reset = 1'b1;
    #1;
    check("rst_async_clear", {press, long_press, click, long_pulse, double_click}, 32'h0);
    tick(3);
    reset = 1'b0;
    tick(D + 1);
    check("rst_pre_rise", press[0], 0);
    tick(1);
    check("rst_rise", press[0], 1);
    tick(L - 1);
    check("rst_long_pre", long_pulse[0], 0);
    tick(1);
    check("rst_long_pulse", long_pulse[0], 1);
    check("rst_long_level", long_press[0], 1);
    usr_btn[0] = 1'b0;
    tick(D + 2 + G + 20);
    check("rst_no_click", d_click(0), 0);
    check("rst_long_count", d_lp(0), 1);
    check("rst_released", press, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
